// File: rtl/btn_event_decoder.sv
// -----------------------------------------------------------------------------
// btn_event_decoder
//
// Turns the debounced level of one button into the one-cycle events used by
// the alarm-clock setting logic: press, short release, long press and
// auto-repeat while the button stays held.
//
// Ports:
//   clk          : system clock, rising edge
//   reset        : synchronous, active-low reset
//   in_btn       : debounced button level, synchronous to clk (1 = pressed)
//   press_pulse  : one-cycle pulse on a new press
//   short_pulse  : one-cycle pulse on release before the long threshold
//   long_pulse   : one-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse : one-cycle pulse every REPEAT_CYCLES while in long mode
//   held         : high while in long mode
//   repeat_count : repeats issued in the current hold, saturating at 255
// -----------------------------------------------------------------------------
module btn_event_decoder #(
    parameter int unsigned LONG_CYCLES   = 16,
    parameter int unsigned REPEAT_CYCLES = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_btn,
    output logic       press_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] repeat_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             in_q;
    logic             rise;

    // Saturating increment for the 8-bit repeat counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rise = in_btn & ~in_q;

    // in_q tracks the input even while reset is low, so a button held
    // through reset does not look like a fresh press once reset releases.
    always_ff @(posedge clk) begin
        in_q <= in_btn;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            press_pulse  <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            held         <= 1'b0;
            repeat_count <= 8'd0;
        end else begin
            press_pulse  <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (rise) begin
                        press_pulse <= 1'b1;
                        cnt         <= '0;
                        state       <= PRESSED;
                    end
                end

                PRESSED: begin
                    // Release wins over reaching the threshold in the same cycle.
                    if (!in_btn) begin
                        short_pulse <= 1'b1;
                        state       <= IDLE;
                    end else if (cnt == LONG_LAST) begin
                        long_pulse   <= 1'b1;
                        held         <= 1'b1;
                        cnt          <= '0;
                        repeat_count <= 8'd0;
                        state        <= LONG;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LONG: begin
                    // Release ends long mode silently and wins over a repeat.
                    if (!in_btn) begin
                        held  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == REPEAT_LAST) begin
                        repeat_pulse <= 1'b1;
                        cnt          <= '0;
                        repeat_count <= sat_inc8(repeat_count);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    held  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_event_decoder
//
// Directed bench for btn_event_decoder with default parameters: a vector
// table for basic press/short behaviour plus hand-written hold sequences
// for long press, auto-repeat, saturation and reset corner cases.
// -----------------------------------------------------------------------------
module tb_btn_event_decoder;

    localparam int LONG_C = 16;
    localparam int REP_C  = 4;

    logic       clk;
    logic       reset;
    logic       in_btn;
    logic       press_pulse;
    logic       short_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] repeat_count;

    int checks;
    int errors;
    logic [7:0] exp_rc;

    btn_event_decoder #(
        .LONG_CYCLES  (LONG_C),
        .REPEAT_CYCLES(REP_C),
        .CNT_W        (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_btn      (in_btn),
        .press_pulse (press_pulse),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse),
        .held        (held),
        .repeat_count(repeat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       btn;
        logic       p;
        logic       s;
        logic       l;
        logic       r;
        logic       h;
        logic [7:0] rc;
    } vec_t;

    vec_t tbl [16];

    // Drive inputs, take one rising edge, then compare outputs 1 ns later.
    task automatic cyc(input logic r, input logic b,
                       input logic ep, input logic es, input logic el,
                       input logic er, input logic eh, input logic [7:0] erc,
                       input string tag);
        reset  = r;
        in_btn = b;
        @(posedge clk);
        #1;
        checks++;
        if ({press_pulse, short_pulse, long_pulse, repeat_pulse, held, repeat_count}
            !== {ep, es, el, er, eh, erc}) begin
            errors++;
            $display("FAIL %s: got press=%b short=%b long=%b rep=%b held=%b rc=%0d, want press=%b short=%b long=%b rep=%b held=%b rc=%0d",
                     tag, press_pulse, short_pulse, long_pulse, repeat_pulse, held, repeat_count,
                     ep, es, el, er, eh, erc);
        end
    endtask

    // Hold the button for n edges starting from IDLE with the button released.
    // Edge 0 samples the rise; expected events follow the documented timing.
    task automatic hold_seq(input int n, input bit do_release, input string tag);
        logic ep, el, er, eh;
        for (int i = 0; i < n; i++) begin
            ep = (i == 0);
            el = (i == LONG_C);
            er = (i > LONG_C) && (((i - LONG_C) % REP_C) == 0);
            eh = (i >= LONG_C);
            if (el) exp_rc = 8'd0;
            if (er && exp_rc != 8'hFF) exp_rc = exp_rc + 8'd1;
            cyc(1'b1, 1'b1, ep, 1'b0, el, er, eh, exp_rc, $sformatf("%s_i%0d", tag, i));
        end
        if (do_release) begin
            cyc(1'b1, 1'b0, 1'b0, (n <= LONG_C), 1'b0, 1'b0, 1'b0, exp_rc,
                $sformatf("%s_rel", tag));
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp_rc,
                $sformatf("%s_idle", tag));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_rc = 8'd0;
        reset  = 1'b0;
        in_btn = 1'b0;

        //            rst  btn  p  s  l  r  h  rc
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

        // Reset, short press and 1-cycle release / re-press.
        for (int i = 0; i < 16; i++) begin
            cyc(tbl[i].rst_n, tbl[i].btn, tbl[i].p, tbl[i].s, tbl[i].l,
                tbl[i].r, tbl[i].h, tbl[i].rc, $sformatf("vec%0d", i));
        end

        // 30-cycle hold: long, three repeats, silent release.
        hold_seq(30, 1'b1, "hold30");
        checks++;
        if (repeat_count !== 8'd3) begin
            errors++;
            $display("FAIL rc_after_hold30: got %0d want 3", repeat_count);
        end

        // Release sampled exactly at threshold: short wins, rc retained.
        hold_seq(LONG_C, 1'b1, "thresh");

        // 300 repeats: saturation at 255, repeats keep firing.
        hold_seq(LONG_C + 300 * REP_C + 1, 1'b1, "sat");

        // Next long press restarts the repeat count.
        hold_seq(LONG_C + 2 * REP_C - 2, 1'b1, "restart");

        // Reset during LONG with repeat_count=2.
        hold_seq(LONG_C + 2 * REP_C + 1, 1'b0, "midhold");
        exp_rc = 8'd0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "midhold_rst");
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,
                $sformatf("midhold_after%0d", i));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "midhold_rel");
        hold_seq(3, 1'b1, "midhold_repress");

        // Button pressed before and throughout reset, then held 40 cycles.
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,
                $sformatf("thru_rst%0d", i));
        for (int i = 0; i < 40; i++)
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,
                $sformatf("thru_hold%0d", i));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "thru_rel");
        hold_seq(5, 1'b1, "thru_repress");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
